lcd_frame_axi: RTL and testbench

AXI4-Lite register slave that holds a parametrised N_ROWS × N_COLS character frame for the LCD driver and delivers it via a valid/ready handshake. CPU writes into a shadow buffer; an explicit or automatic commit copies the shadow into the output frame and raises `lcd_valid` until the driver accepts it. Adds busy/done/overrun status, SLVERR on unmapped addresses, and a maskable interrupt. It replaces the fixed 2×16 control block between the PS AXI interconnect and the LCD character driver.

---
 rtl/lcd_frame_axi.sv | 215 +++++++++++++++++++++
 tb/tb_lcd_frame_axi.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_axi.sv
// AXI4-Lite character-frame buffer for the LCD driver.
// The CPU fills a shadow text buffer; a commit (START or AUTO) copies it into
// the output frame, which is offered to the driver with a valid/ready handshake.
module lcd_frame_axi #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int N_ROWS             = 2,
    parameter int N_COLS             = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic                            lcd_ready,
    output logic                            lcd_valid,
    output logic [8*N_ROWS*N_COLS-1:0]      lcd_data,
    output logic                            irq
);

    localparam int         FW         = 8 * N_ROWS * N_COLS;
    localparam int         NW         = N_ROWS * N_COLS / 4;
    localparam int         FAW        = $clog2(FW);
    localparam logic [5:0] NW_IDX     = 6'(NW);
    localparam logic [5:0] IDX_CTRL   = 6'd60;
    localparam logic [5:0] IDX_STATUS = 6'd61;
    localparam logic [5:0] IDX_IRQEN  = 6'd62;

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [FW-1:0]     shadow;
    logic [FW-1:0]     frame;
    logic              auto_mode;
    logic              done;
    logic              overrun;
    logic              dirty;
    logic [1:0]        irq_en;

    logic [5:0]        wr_idx;
    logic [5:0]        rd_idx;
    logic [FAW-1:0]    wr_base;
    logic [FAW-1:0]    rd_base;
    logic              wr_en;
    logic              wr_text;
    logic              wr_ctrl;
    logic              wr_status;
    logic              wr_irqen;
    logic              wr_map;
    logic              start_wr;
    logic              commit;
    logic              handshake;
    logic              rd_en;
    logic              rd_map;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
    logic              unused_bits;

    // Protection bits and sub-word address bits carry no meaning here.
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_idx    = S_AXI_AWADDR[7:2];
    assign rd_idx    = S_AXI_ARADDR[7:2];
    assign wr_base   = FAW'({wr_idx, 5'b00000});
    assign rd_base   = FAW'({rd_idx, 5'b00000});

    // AWREADY and WREADY are one and the same pulse.
    assign S_AXI_WREADY = S_AXI_AWREADY;
    assign wr_en     = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_en     = S_AXI_ARREADY && S_AXI_ARVALID;

    assign wr_text   = wr_en && (wr_idx < NW_IDX);
    assign wr_ctrl   = wr_en && (wr_idx == IDX_CTRL) && S_AXI_WSTRB[0];
    assign wr_status = wr_en && (wr_idx == IDX_STATUS) && S_AXI_WSTRB[0];
    assign wr_irqen  = wr_en && (wr_idx == IDX_IRQEN) && S_AXI_WSTRB[0];
    assign wr_map    = (wr_idx < NW_IDX) || (wr_idx == IDX_CTRL) ||
                       (wr_idx == IDX_STATUS) || (wr_idx == IDX_IRQEN);

    assign start_wr  = wr_ctrl && S_AXI_WDATA[0];
    // Auto-commit waits for a cycle with no accepted write so a burst of
    // text writes is not chopped into partial frames mid-write.
    assign commit    = (state == IDLE) &&
                       (start_wr || (auto_mode && dirty && !wr_en));
    assign handshake = (state == SEND) && lcd_ready;

    assign lcd_valid = (state == SEND);
    assign lcd_data  = frame;

    // Write address/data acceptance and write response channel.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
        end else begin
            S_AXI_AWREADY <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_AWREADY && !S_AXI_BVALID;
            if (wr_en) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= wr_map ? 2'b00 : 2'b10;
            end else if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
        end
    end

    // Read data selection for the addressed register.
    always_comb begin
        rd_word = '0;
        rd_map  = 1'b1;
        if (rd_idx < NW_IDX)
            rd_word = shadow[rd_base +: 32];
        else if (rd_idx == IDX_CTRL)
            rd_word = {30'b0, auto_mode, 1'b0};
        else if (rd_idx == IDX_STATUS)
            rd_word = {27'b0, lcd_ready, dirty, overrun, done, lcd_valid};
        else if (rd_idx == IDX_IRQEN)
            rd_word = {30'b0, irq_en};
        else
            rd_map = 1'b0;
    end

    // Read address acceptance and read data channel.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RRESP   <= 2'b00;
            S_AXI_RDATA   <= '0;
        end else begin
            S_AXI_ARREADY <= S_AXI_ARVALID && !S_AXI_ARREADY && !S_AXI_RVALID;
            if (rd_en) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_word;
                S_AXI_RRESP  <= rd_map ? 2'b00 : 2'b10;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

    // Frame FSM state register.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Frame FSM next state: commit starts a send, the handshake ends it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (commit) state_nxt = SEND;
            SEND:    if (handshake) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow text, committed frame and control/status registers.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            shadow    <= '0;
            frame     <= '0;
            auto_mode <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            dirty     <= 1'b0;
            irq_en    <= 2'b00;
            irq       <= 1'b0;
        end else begin
            if (wr_text) begin
                for (int b = 0; b < 4; b++)
                    if (S_AXI_WSTRB[b])
                        shadow[wr_base + FAW'(8 * b) +: 8] <= S_AXI_WDATA[8 * b +: 8];
            end
            if (commit)
                frame <= shadow;
            if (wr_ctrl)
                auto_mode <= S_AXI_WDATA[1];
            if (wr_irqen)
                irq_en <= S_AXI_WDATA[1:0];
            if (wr_text)
                dirty <= 1'b1;
            else if (commit)
                dirty <= 1'b0;
            // Sticky set takes priority over a W1C clear in the same cycle.
            if (handshake)
                done <= 1'b1;
            else if (wr_status && S_AXI_WDATA[1])
                done <= 1'b0;
            if (start_wr && state == SEND)
                overrun <= 1'b1;
            else if (wr_status && S_AXI_WDATA[2])
                overrun <= 1'b0;
            irq <= (irq_en[0] && done) || (irq_en[1] && overrun);
        end
    end

endmodule

// File: tb/tb_lcd_frame_axi.sv
// Randomized self-checking bench for lcd_frame_axi against a register-level model.
module tb_lcd_frame_axi;

    localparam int NR = 2;
    localparam int NC = 16;
    localparam int NB = NR * NC;
    localparam int NW = NB / 4;
    localparam int FW = 8 * NB;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [7:0]    araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic          lcd_ready;
    logic          lcd_valid;
    logic [FW-1:0] lcd_data;
    logic          irq;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0] m_shadow [NB];
    logic [7:0] m_frame  [NB];
    logic       m_auto, m_done, m_over, m_dirty, m_busy;
    logic [1:0] m_irqen;

    always #5 clk = ~clk;

    lcd_frame_axi #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8), .N_ROWS(NR), .N_COLS(NC)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp),
        .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
        .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready), .lcd_ready(lcd_ready), .lcd_valid(lcd_valid),
        .lcd_data(lcd_data), .irq(irq)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] m_frame_vec();
        logic [FW-1:0] v;
        for (int k = 0; k < NB; k++) v[8*k +: 8] = m_frame[k];
        return v;
    endfunction

    function automatic logic m_irq();
        return (m_irqen[0] & m_done) | (m_irqen[1] & m_over);
    endfunction

    task automatic m_reset();
        for (int k = 0; k < NB; k++) begin
            m_shadow[k] = 8'h00;
            m_frame[k]  = 8'h00;
        end
        m_auto = 0; m_done = 0; m_over = 0; m_dirty = 0; m_busy = 0; m_irqen = 2'b00;
    endtask

    task automatic m_commit();
        for (int k = 0; k < NB; k++) m_frame[k] = m_shadow[k];
        m_dirty = 0;
        m_busy  = 1;
    endtask

    task automatic m_apply(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx = int'(a[7:2]);
        if (idx < NW) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_shadow[4*idx + b] = d[8*b +: 8];
            m_dirty = 1;
        end else if (idx == 60 && s[0]) begin
            if (d[0]) begin
                if (m_busy) m_over = 1;
                else m_commit();
            end
            m_auto = d[1];
        end else if (idx == 61 && s[0]) begin
            if (d[1]) m_done = 0;
            if (d[2]) m_over = 0;
        end else if (idx == 62 && s[0]) begin
            m_irqen = d[1:0];
        end
        if (m_auto && m_dirty && !m_busy) m_commit();
    endtask

    task automatic m_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        int idx = int'(a[7:2]);
        d = 32'h0;
        r = 2'b00;
        if (idx < NW)
            d = {m_shadow[4*idx+3], m_shadow[4*idx+2], m_shadow[4*idx+1], m_shadow[4*idx]};
        else if (idx == 60) d = {30'b0, m_auto, 1'b0};
        else if (idx == 61) d = {27'b0, lcd_ready, m_dirty, m_over, m_done, m_busy};
        else if (idx == 62) d = {30'b0, m_irqen};
        else r = 2'b10;
    endtask

    // Starts and ends #1 after a rising edge; lv2 is lcd_valid in the cycle after accept.
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic lv2);
        int lat = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        @(negedge clk);
        while (!awready && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        chk("aw_latency", lat, 1);
        chk("wready", wready, 1);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; bready = 1;
        @(negedge clk);
        chk("bvalid", bvalid, 1);
        resp = bresp;
        lv2  = lcd_valid;
        @(posedge clk); #1;
        bready = 0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        int lat = 0;
        araddr = a; arvalid = 1;
        @(negedge clk);
        while (!arready && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        chk("ar_latency", lat, 1);
        @(posedge clk); #1;
        arvalid = 0; rready = 1;
        @(negedge clk);
        chk("rvalid", rvalid, 1);
        d = rdata;
        r = rresp;
        @(posedge clk); #1;
        rready = 0;
    endtask

    task automatic read_cmp(input logic [7:0] a, input string tag);
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        axi_read(a, d, r);
        m_read(a, ed, er);
        chk({tag, "_rdata"}, d, ed);
        chk({tag, "_rresp"}, r, er);
    endtask

    task automatic write_m(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input string tag);
        logic [1:0] r;
        logic       lv;
        axi_write(a, d, s, r, lv);
        m_apply(a, d, s);
        chk({tag, "_bresp"}, r, 2'b00);
    endtask

    task automatic read_all(input string tag);
        for (int w = 0; w < NW; w++) read_cmp(8'(4*w), tag);
        read_cmp(8'hF0, tag);
        read_cmp(8'hF4, tag);
        read_cmp(8'hF8, tag);
    endtask

    // Holds lcd_ready low for dly cycles, then handshakes for one cycle.
    task automatic handshake(input int dly);
        logic stable = 1;
        logic irq_old = m_irq();
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            if (!lcd_valid || lcd_data !== m_frame_vec()) stable = 0;
            @(posedge clk); #1;
        end
        lcd_ready = 1;
        @(negedge clk);
        if (!lcd_valid || lcd_data !== m_frame_vec()) stable = 0;
        chk("send_hold", stable, 1);
        @(posedge clk); #1;
        lcd_ready = 0;
        m_busy = 0;
        m_done = 1;
        @(negedge clk);
        chk("valid_drop", lcd_valid, 0);
        chk("irq_k1", irq, irq_old);
        @(posedge clk); #1;
        @(negedge clk);
        chk("irq_k2", irq, m_irq());
        @(posedge clk); #1;
        if (m_auto && m_dirty) m_commit();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic        lv;
        logic [7:0]  a;
        int          op;

        rst = 1; lcd_ready = 1;
        awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        araddr = 0; arprot = 0; arvalid = 0; rready = 0;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_resp", {bresp, rresp}, 0);
        chk("rst_lcd_valid", lcd_valid, 0);
        chk("rst_lcd_data", lcd_data, 0);
        chk("rst_irq", irq, 0);
        @(posedge clk); #1;
        rst = 0;
        axi_read(8'hF4, d, r);
        chk("rst_status", d, 32'h10);
        lcd_ready = 0;
        read_cmp(8'hF4, "status_nordy");

        // First frame: "HELL" committed by START, slow driver
        axi_write(8'h00, 32'h4C4C4548, 4'hF, r, lv);
        m_apply(8'h00, 32'h4C4C4548, 4'hF);
        chk("text_bresp", r, 0);
        chk("no_auto_commit", lv, 0);
        axi_write(8'hF0, 32'h1, 4'hF, r, lv);
        m_apply(8'hF0, 32'h1, 4'hF);
        chk("start_latency", lv, 1);
        chk("hell_data", lcd_data[31:0], 32'h4C4C4548);
        chk("hell_frame", lcd_data, m_frame_vec());
        handshake(5);
        axi_read(8'hF4, d, r);
        chk("status_done", d, 32'h02);
        write_m(8'hF4, 32'h2, 4'hF, "w1c_done");
        read_cmp(8'hF4, "status_clr");

        // Overrun during SEND and its interrupt
        write_m(8'hF8, 32'h2, 4'hF, "irqen");
        write_m(8'hF0, 32'h1, 4'hF, "start2");
        write_m(8'hF0, 32'h1, 4'hF, "start_busy");
        axi_read(8'hF4, d, r);
        chk("status_overrun", d, 32'h05);
        chk("irq_overrun", irq, 1);
        write_m(8'hF4, 32'h4, 4'hF, "w1c_over");
        chk("irq_cleared", irq, m_irq());
        write_m(8'hF8, 32'h1, 4'hF, "irqen_done");
        handshake(2);
        write_m(8'hF4, 32'h2, 4'hF, "w1c_done2");
        chk("irq_done_clr", irq, 0);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                a = 8'(4 * $urandom_range(0, NW - 1));
                d = $urandom;
                write_m(a, d, 4'($urandom_range(1, 15)), "rnd_text");
            end else if (op <= 5) begin
                read_cmp(8'(4 * $urandom_range(0, NW - 1)), "rnd_read");
            end else if (op <= 7) begin
                if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(252, 255));
                else a = 8'($urandom_range(NW * 4, 239));
                if (op == 6) begin
                    axi_write(a, $urandom, 4'hF, r, lv);
                    chk("unmapped_bresp", r, 2'b10);
                end else begin
                    axi_read(a, d, r);
                    chk("unmapped_rresp", r, 2'b10);
                    chk("unmapped_rdata", d, 0);
                end
            end else begin
                axi_write(8'hF0, 32'h1, 4'hF, r, lv);
                m_apply(8'hF0, 32'h1, 4'hF);
                chk("rnd_start", lv, 1);
                chk("rnd_frame", lcd_data, m_frame_vec());
                for (int j = 0; j < int'($urandom_range(0, 2)); j++)
                    write_m(8'(4 * $urandom_range(0, NW - 1)), $urandom, 4'hF, "send_text");
                chk("send_frame", lcd_data, m_frame_vec());
                handshake($urandom_range(0, 4));
                read_cmp(8'hF4, "rnd_status");
                write_m(8'hF4, 32'h2, 4'hF, "rnd_w1c");
            end
        end

        // Automatic commit with a single-byte strobe
        write_m(8'hF0, 32'h2, 4'hF, "auto_on");
        if (m_busy) handshake(1);
        axi_write(8'h04, 32'h0000AA00, 4'b0010, r, lv);
        m_apply(8'h04, 32'h0000AA00, 4'b0010);
        chk("auto_not_yet", lv, 0);
        @(negedge clk);
        chk("auto_commit", lcd_valid, 1);
        chk("auto_frame", lcd_data, m_frame_vec());
        @(posedge clk); #1;
        read_cmp(8'hF4, "auto_status");
        handshake(1);
        read_cmp(8'h04, "auto_word1");
        write_m(8'hF0, 32'h0, 4'hF, "auto_off");
        write_m(8'hF4, 32'h2, 4'hF, "auto_w1c");

        // Unmapped 0x80 leaves everything untouched
        axi_write(8'h80, 32'hFFFFFFFF, 4'hF, r, lv);
        chk("x80_bresp", r, 2'b10);
        axi_read(8'h80, d, r);
        chk("x80_rresp", r, 2'b10);
        chk("x80_rdata", d, 0);
        read_all("x80_regs");

        // Reset while a frame is pending
        write_m(8'hF8, 32'h3, 4'hF, "pre_rst_irqen");
        axi_write(8'hF0, 32'h3, 4'hF, r, lv);
        m_apply(8'hF0, 32'h3, 4'hF);
        chk("pre_rst_valid", lv, 1);
        rst = 1;
        @(posedge clk); #1;
        chk("rst_send_valid", lcd_valid, 0);
        chk("rst_send_data", lcd_data, 0);
        rst = 0;
        m_reset();
        read_all("post_rst");
        chk("post_rst_irq", irq, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
